tile_scheduler: RTL and testbench
=================================

Name: tile_scheduler

Overview:
Sequences the rendering of one frame as a raster of 32x32 tiles. It hands tile origins to the rasterizer and to tile_writer, and ping-pongs between two tile buffers so that rasterizing tile N+1 overlaps the DDR3 writeback of tile N. It sits between the frame-level command logic and the rasterizer/tile_writer pair, and owns the tile-buffer ownership flags.

Parameters:
SCREEN_W, 640, frame width in pixels; must be a multiple of TILE_W
SCREEN_H, 480, frame height in pixels; must be a multiple of TILE_H
TILE_W, 32, tile width in pixels
TILE_H, 32, tile height in pixels

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
frame_start  in  1  pulse; begin a frame (ignored while frame_busy)
frame_busy  out  1  high from frame accept until frame_done
frame_done  out  1  one-cycle pulse when the last tile's writeback completes
rast_start  out  1  one-cycle pulse; rasterize tile into rast_buf_sel
rast_done  in  1  pulse; rasterizer finished the current tile
rast_tile_px  out  16  tile origin X (pixels), stable from rast_start until rast_done
rast_tile_py  out  16  tile origin Y (pixels), same stability rule
rast_buf_sel  out  1  tile buffer index written by the rasterizer
wr_start  out  1  one-cycle pulse to tile_writer.start
wr_done  in  1  tile_writer.done pulse
wr_tile_px  out  16  to tile_writer.tile_px; stable from wr_start until wr_done
wr_tile_py  out  16  to tile_writer.tile_py; same stability rule
wr_buf_sel  out  1  tile buffer index read by tile_writer (selects BRAM read mux)
perf_stall_cycles  out  32  rasterizer-stall cycle count (see Optional Feature)

Behaviour:
- Reset values: all pulses 0, frame_busy 0, both buf_sel 0, all tile_px/py 0, full[1:0] 0, perf 0. Both FSMs go to IDLE.
- Reset mid-frame abandons the frame. No done pulse is generated. External blocks are reset by the same signal.
- Tile order is row-major: tx = 0..SCREEN_W/TILE_W-1, then ty. Default frame is 20x15 = 300 tiles.
- Origins: px = tx*TILE_W, py = ty*TILE_H, zero-extended to 16 bits.
- Buffer state: full[b] set on rast_done for the rasterizer's buffer; cleared on wr_done for the writer's buffer. Per-buffer origin registers buf_px[b]/buf_py[b] are captured at rast_start.
- Frame FSM:
  - F_IDLE -> F_RUN on frame_start. Clear tile counters, rbuf = wbuf = 0; frame_busy <= 1.
  - F_RUN -> F_DONE when all tiles are rasterized, full == 0, and the writer FSM is in W_IDLE.
  - F_DONE: frame_done <= 1, frame_busy <= 0, -> F_IDLE.
- Raster FSM:
  - R_IDLE: when in F_RUN with tiles remaining and !full[rbuf] and !(writer active on rbuf), go to R_ISSUE.
  - R_ISSUE: rast_start <= 1 and drive coords, -> R_WAIT.
  - R_WAIT: on rast_done, set full[rbuf], toggle rbuf, advance tile counter, -> R_IDLE.
  - The first rast_start occurs 2 cycles after the frame_start cycle.
- Writer FSM:
  - W_IDLE: when full[wbuf], go to W_ISSUE with wr_tile_px/py <= buf_px/py[wbuf].
  - W_ISSUE: wr_start <= 1, -> W_WAIT.
  - W_WAIT: on wr_done, clear full[wbuf], toggle wbuf, -> W_IDLE.
- Ordering: tiles are written in the order they were rasterized. The writer never starts on a buffer that is not full. The rasterizer never targets a full buffer or the buffer being written.
- Simultaneous rast_done and wr_done always hit different buffers, so both updates apply in the same cycle.
- rast_done/wr_done arriving in any other state are ignored.
- frame_start while busy is ignored; no queuing.

Optional Feature:
TILE_SCHED_PERF_EN:
- Defined: perf_stall_cycles increments (saturating at 0xFFFFFFFF) on every F_RUN cycle where the raster FSM is in R_IDLE with tiles remaining but blocked by buffer ownership. It is cleared on frame accept and holds after frame_done.
- Undefined: the port is present and tied to 0, with no counter logic.

Decomposition:
- Package tile_pkg: TILE_W/TILE_H/SCREEN_W/SCREEN_H defaults, FB_BASE and stride constants shared with tile_writer, and enum typedefs for the frame, raster and writer FSM states.
- No sub-module is needed. The tile x/y counter may be a small local sub-module, tile_coord_counter (count enable, wrap flags, last-tile flag).

Test Plan:
- Bench uses SCREEN_W=64, SCREEN_H=64 (4 tiles) with instant rast_done/wr_done 1 cycle after each start. Expect rast origins (0,0),(32,0),(0,32),(32,32) with buf_sel 0,1,0,1; wr origins in the same order; exactly one frame_done; frame_busy then 0.
- Slow writer (wr_done 50 cycles after wr_start), fast rasterizer (5 cycles). The 3rd rast_start must wait until the first wr_done. With PERF_EN, perf_stall_cycles is > 0 and exact against the bench's model.
- Slow rasterizer (40 cycles), fast writer (3 cycles). wr_start follows each rast_done by exactly 2 cycles; perf_stall_cycles = 0.
- frame_start pulsed again mid-frame: ignored, and the tile sequence is unchanged.
- Reset asserted during a writer W_WAIT: all outputs return to reset values the next cycle. A subsequent frame_start restarts from tile (0,0) on buffer 0.
- Default 640x480 frame: 300 rast_start and 300 wr_start pulses. The last wr origin is (608,448) and frame_done follows the 300th wr_done by 2 cycles.

Source files
------------

// File: rtl/tile_pkg.sv
// Shared types and constants for the tile scheduler and its tile_writer peer.
// Holds the default frame/tile geometry, framebuffer layout constants, the
// tile-origin payload struct and the state enums of the three scheduler FSMs.
package tile_pkg;

  localparam int unsigned TILE_W_DEF   = 32;
  localparam int unsigned TILE_H_DEF   = 32;
  localparam int unsigned SCREEN_W_DEF = 640;
  localparam int unsigned SCREEN_H_DEF = 480;

  localparam int unsigned COORD_W = 16;
  localparam int unsigned PERF_W  = 32;

  // Framebuffer layout, shared with tile_writer (16-bit pixels).
  localparam logic [31:0] FB_BASE      = 32'h0000_0000;
  localparam int unsigned BYTES_PER_PX = 2;
  localparam int unsigned FB_STRIDE    = SCREEN_W_DEF * BYTES_PER_PX;

  typedef logic [COORD_W-1:0] coord_t;

  // Tile origin in pixels.
  typedef struct packed {
    coord_t px;
    coord_t py;
  } tile_org_t;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_RUN  = 2'd1,
    F_DONE = 2'd2
  } frame_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ISSUE = 2'd1,
    R_WAIT  = 2'd2
  } rast_state_t;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_ISSUE = 2'd1,
    W_WAIT  = 2'd2
  } wr_state_t;

endpackage

// File: rtl/tile_scheduler_if.sv
// Handshake bundle between tile_scheduler and its environment:
//   frame_start/frame_busy/frame_done   frame-level command handshake
//   rast_*                               rasterizer start/done + tile origin
//   wr_*                                 tile_writer start/done + tile origin
//   perf_stall_cycles                    rasterizer stall counter
// master = scheduler side, slave = frame logic / rasterizer / tile_writer side.
interface tile_scheduler_if;
  import tile_pkg::*;

  logic              frame_start;
  logic              frame_busy;
  logic              frame_done;
  logic              rast_start;
  logic              rast_done;
  coord_t            rast_tile_px;
  coord_t            rast_tile_py;
  logic              rast_buf_sel;
  logic              wr_start;
  logic              wr_done;
  coord_t            wr_tile_px;
  coord_t            wr_tile_py;
  logic              wr_buf_sel;
  logic [PERF_W-1:0] perf_stall_cycles;

  modport master (
    input  frame_start, rast_done, wr_done,
    output frame_busy, frame_done,
           rast_start, rast_tile_px, rast_tile_py, rast_buf_sel,
           wr_start, wr_tile_px, wr_tile_py, wr_buf_sel,
           perf_stall_cycles
  );

  modport slave (
    output frame_start, rast_done, wr_done,
    input  frame_busy, frame_done,
           rast_start, rast_tile_px, rast_tile_py, rast_buf_sel,
           wr_start, wr_tile_px, wr_tile_py, wr_buf_sel,
           perf_stall_cycles
  );

endinterface

// File: rtl/tile_scheduler_coord_counter.sv
// tile_coord_counter: row-major tile origin counter in pixel units.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clear        restart at tile (0,0)
//   en           advance to the next tile (wraps to (0,0) after the last)
//   px, py       current tile origin (registered)
//   last_c       current tile is the last tile of the frame
module tile_coord_counter
  import tile_pkg::*;
#(
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF,
  parameter int unsigned TILE_W   = TILE_W_DEF,
  parameter int unsigned TILE_H   = TILE_H_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   clear,
  input  logic   en,
  output coord_t px,
  output coord_t py,
  output logic   last_c
);

  localparam coord_t X_LAST = COORD_W'(SCREEN_W - TILE_W);
  localparam coord_t Y_LAST = COORD_W'(SCREEN_H - TILE_H);

  logic x_wrap;

  assign x_wrap = (px == X_LAST);
  assign last_c = x_wrap && (py == Y_LAST);

  // Step X by one tile; on X wrap step Y; after the last tile return to origin.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      px <= '0;
      py <= '0;
    end else if (en) begin
      if (x_wrap) begin
        px <= '0;
        py <= last_c ? '0 : py + COORD_W'(TILE_H);
      end else begin
        px <= px + COORD_W'(TILE_W);
      end
    end
  end

endmodule

// File: rtl/tile_scheduler.sv
// tile_scheduler: walks one frame as a raster of tiles, handing origins to the
// rasterizer and tile_writer and ping-ponging two tile buffers so that
// rasterizing tile N+1 overlaps the writeback of tile N.
// Ports:
//   clk, reset   clock, synchronous active-high reset (abandons any frame)
//   bus          tile_scheduler_if.master (frame, rasterizer, writer handshakes)
// Build option:
//   TILE_SCHED_PERF_EN  when defined, perf_stall_cycles counts cycles in which
//                       the rasterizer is idle with tiles left but both buffers
//                       are unavailable; otherwise the output is tied to 0.
module tile_scheduler
  import tile_pkg::*;
#(
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF,
  parameter int unsigned TILE_W   = TILE_W_DEF,
  parameter int unsigned TILE_H   = TILE_H_DEF
) (
  input logic             clk,
  input logic             reset,
  tile_scheduler_if.master bus
);

  frame_state_t f_state, f_next;
  rast_state_t  r_state, r_next;
  wr_state_t    w_state, w_next;

  logic       frame_busy_q, frame_busy_d;
  logic       frame_done_q, frame_done_d;
  logic       rast_start_q, rast_start_d;
  logic       wr_start_q,   wr_start_d;
  coord_t     rast_px_q, rast_py_q;
  coord_t     wr_px_q,   wr_py_q;
  logic       rbuf, wbuf;
  logic [1:0] full;
  logic       all_rast;
  tile_org_t  buf_org [2];

  coord_t cnt_px, cnt_py;
  logic   cnt_last_c;

  logic frame_accept, wr_on_rbuf, rast_blocked, rast_eligible;
  logic rast_go, rast_fin, wr_go, wr_fin;

  // Handshake qualifiers; done pulses outside the WAIT states are ignored.
  assign frame_accept  = (f_state == F_IDLE) && bus.frame_start;
  assign wr_on_rbuf    = (w_state != W_IDLE) && (wbuf == rbuf);
  assign rast_blocked  = full[rbuf] || wr_on_rbuf;
  assign rast_eligible = (f_state == F_RUN) && !all_rast && (r_state == R_IDLE);
  assign rast_go       = rast_eligible && !rast_blocked;
  assign rast_fin      = (r_state == R_WAIT) && bus.rast_done;
  assign wr_go         = (w_state == W_IDLE) && full[wbuf];
  assign wr_fin        = (w_state == W_WAIT) && bus.wr_done;

  tile_coord_counter #(
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H),
    .TILE_W  (TILE_W),
    .TILE_H  (TILE_H)
  ) u_coord (
    .clk   (clk),
    .reset (reset),
    .clear (frame_accept),
    .en    (rast_fin),
    .px    (cnt_px),
    .py    (cnt_py),
    .last_c(cnt_last_c)
  );

  // Frame FSM: busy while running, done pulses as it enters F_DONE.
  always_comb begin
    f_next       = f_state;
    frame_busy_d = frame_busy_q;
    frame_done_d = 1'b0;
    case (f_state)
      F_IDLE: begin
        if (bus.frame_start) begin
          f_next       = F_RUN;
          frame_busy_d = 1'b1;
        end
      end
      F_RUN: begin
        if (all_rast && (full == 2'b00) && (w_state == W_IDLE)) begin
          f_next       = F_DONE;
          frame_busy_d = 1'b0;
          frame_done_d = 1'b1;
        end
      end
      F_DONE:  f_next = F_IDLE;
      default: f_next = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_state      <= F_IDLE;
      frame_busy_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      f_state      <= f_next;
      frame_busy_q <= frame_busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Raster FSM: rast_start is high for the single R_ISSUE cycle.
  always_comb begin
    r_next       = r_state;
    rast_start_d = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (rast_go) begin
          r_next       = R_ISSUE;
          rast_start_d = 1'b1;
        end
      end
      R_ISSUE: r_next = R_WAIT;
      R_WAIT:  if (bus.rast_done) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Raster datapath: origins latched at issue, buffer flips on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= R_IDLE;
      rast_start_q <= 1'b0;
      rast_px_q    <= '0;
      rast_py_q    <= '0;
      rbuf         <= 1'b0;
      all_rast     <= 1'b0;
      buf_org[0]   <= '0;
      buf_org[1]   <= '0;
    end else begin
      r_state      <= r_next;
      rast_start_q <= rast_start_d;
      if (frame_accept) begin
        rbuf     <= 1'b0;
        all_rast <= 1'b0;
      end
      if (rast_go) begin
        rast_px_q     <= cnt_px;
        rast_py_q     <= cnt_py;
        buf_org[rbuf] <= '{px: cnt_px, py: cnt_py};
      end
      if (rast_fin) begin
        rbuf <= ~rbuf;
        if (cnt_last_c) all_rast <= 1'b1;
      end
    end
  end

  // Buffer ownership; a simultaneous set and clear always hit different bits.
  always_ff @(posedge clk) begin
    if (reset || frame_accept) begin
      full <= 2'b00;
    end else begin
      if (rast_fin) full[rbuf] <= 1'b1;
      if (wr_fin)   full[wbuf] <= 1'b0;
    end
  end

  // Writer FSM: drains buffers strictly in rasterization order.
  always_comb begin
    w_next     = w_state;
    wr_start_d = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (wr_go) begin
          w_next     = W_ISSUE;
          wr_start_d = 1'b1;
        end
      end
      W_ISSUE: w_next = W_WAIT;
      W_WAIT:  if (bus.wr_done) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state    <= W_IDLE;
      wr_start_q <= 1'b0;
      wr_px_q    <= '0;
      wr_py_q    <= '0;
      wbuf       <= 1'b0;
    end else begin
      w_state    <= w_next;
      wr_start_q <= wr_start_d;
      if (frame_accept) wbuf <= 1'b0;
      if (wr_go) begin
        wr_px_q <= buf_org[wbuf].px;
        wr_py_q <= buf_org[wbuf].py;
      end
      if (wr_fin) wbuf <= ~wbuf;
    end
  end

`ifdef TILE_SCHED_PERF_EN
  logic [PERF_W-1:0] perf_q;

  // Saturating stall counter, restarted on each accepted frame.
  always_ff @(posedge clk) begin
    if (reset || frame_accept) begin
      perf_q <= '0;
    end else if (rast_eligible && rast_blocked && (perf_q != '1)) begin
      perf_q <= perf_q + PERF_W'(1);
    end
  end

  assign bus.perf_stall_cycles = perf_q;
`else
  assign bus.perf_stall_cycles = '0;
`endif

  assign bus.frame_busy   = frame_busy_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.rast_start   = rast_start_q;
  assign bus.rast_tile_px = rast_px_q;
  assign bus.rast_tile_py = rast_py_q;
  assign bus.rast_buf_sel = rbuf;
  assign bus.wr_start     = wr_start_q;
  assign bus.wr_tile_px   = wr_px_q;
  assign bus.wr_tile_py   = wr_py_q;
  assign bus.wr_buf_sel   = wbuf;

endmodule

// File: tb/tb_tile_scheduler.sv
// Self-checking bench for tile_scheduler: a 64x64 (2x2 tiles) instance and a
// default 640x480 instance share stimulus; use_big selects which one is driven
// and observed. Expected origins, buffer indices, pulse timing and stall counts
// come from a tile-index model driven by the bench's own done timestamps.
module tb_tile_scheduler;
  import tile_pkg::*;

  localparam int NEVER  = 1_000_000_000;
  localparam int BUDGET = 20000;
  localparam int MAXT   = 300;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic frame_start_d = 1'b0, rast_done_d = 1'b0, wr_done_d = 1'b0, use_big = 1'b0;

  tile_scheduler_if s_if ();
  tile_scheduler_if b_if ();

  assign s_if.frame_start = frame_start_d & ~use_big;
  assign s_if.rast_done   = rast_done_d   & ~use_big;
  assign s_if.wr_done     = wr_done_d     & ~use_big;
  assign b_if.frame_start = frame_start_d &  use_big;
  assign b_if.rast_done   = rast_done_d   &  use_big;
  assign b_if.wr_done     = wr_done_d     &  use_big;

  tile_scheduler #(.SCREEN_W(64), .SCREEN_H(64), .TILE_W(32), .TILE_H(32))
    dut_s (.clk(clk), .reset(reset), .bus(s_if));
  tile_scheduler dut_b (.clk(clk), .reset(reset), .bus(b_if));

  wire [101:0] s_outs = {s_if.frame_busy, s_if.frame_done, s_if.rast_start,
                         s_if.rast_tile_px, s_if.rast_tile_py, s_if.rast_buf_sel,
                         s_if.wr_start, s_if.wr_tile_px, s_if.wr_tile_py,
                         s_if.wr_buf_sel, s_if.perf_stall_cycles};
  wire [101:0] b_outs = {b_if.frame_busy, b_if.frame_done, b_if.rast_start,
                         b_if.rast_tile_px, b_if.rast_tile_py, b_if.rast_buf_sel,
                         b_if.wr_start, b_if.wr_tile_px, b_if.wr_tile_py,
                         b_if.wr_buf_sel, b_if.perf_stall_cycles};

  wire        o_busy = use_big ? b_if.frame_busy   : s_if.frame_busy;
  wire        o_done = use_big ? b_if.frame_done   : s_if.frame_done;
  wire        o_rs   = use_big ? b_if.rast_start   : s_if.rast_start;
  wire [15:0] o_rpx  = use_big ? b_if.rast_tile_px : s_if.rast_tile_px;
  wire [15:0] o_rpy  = use_big ? b_if.rast_tile_py : s_if.rast_tile_py;
  wire        o_rsel = use_big ? b_if.rast_buf_sel : s_if.rast_buf_sel;
  wire        o_ws   = use_big ? b_if.wr_start     : s_if.wr_start;
  wire [15:0] o_wpx  = use_big ? b_if.wr_tile_px   : s_if.wr_tile_px;
  wire [15:0] o_wpy  = use_big ? b_if.wr_tile_py   : s_if.wr_tile_py;
  wire        o_wsel = use_big ? b_if.wr_buf_sel   : s_if.wr_buf_sel;
  wire [31:0] o_perf = use_big ? b_if.perf_stall_cycles : s_if.perf_stall_cycles;

  int vectors = 0, miscompares = 0;
  int tiles_x, n_tiles;
  int rs_cyc [MAXT], ws_cyc [MAXT], rd [MAXT], wd [MAXT];
  int rs_n, ws_n, fd_n, fd_cyc, accept_cyc;
  longint stall;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [15:0] org_x(input int k);
    return 16'((k % tiles_x) * 32);
  endfunction

  function automatic logic [15:0] org_y(input int k);
    return 16'((k / tiles_x) * 32);
  endfunction

  // Runs one frame with random done latencies in [min,max]; optionally pulses
  // frame_start while busy, or stops abort_after cycles after the first wr_start.
  task automatic run_frame(input int rmin, input int rmax, input int wmin,
                           input int wmax, input bit spam, input int abort_after);
    int rdone_at, wdone_at, k, c, e;
    logic [31:0] exp_perf;
    rs_n = 0; ws_n = 0; fd_n = 0; fd_cyc = NEVER; stall = 0;
    rdone_at = -1; wdone_at = -1;
    for (int i = 0; i < MAXT; i++) begin
      rs_cyc[i] = NEVER; ws_cyc[i] = NEVER; rd[i] = NEVER; wd[i] = NEVER;
    end
    @(negedge clk);
    frame_start_d = 1'b1;
    accept_cyc = cyc;
    for (int t = 0; t < BUDGET; t++) begin
      @(negedge clk);
      c = cyc;
      frame_start_d = 1'b0; rast_done_d = 1'b0; wr_done_d = 1'b0;
      if (abort_after > 0 && ws_n > 0 && c == ws_cyc[0] + abort_after) return;
      if (o_rs) begin
        k = rs_n;
        if (k < n_tiles && k < MAXT) begin
          vectors++;
          if ({o_rpx, o_rpy, o_rsel} !== {org_x(k), org_y(k), 1'(k % 2)}) begin
            miscompares++;
            $display("FAIL rast_origin tile %0d: got (%0d,%0d) buf %0d, want (%0d,%0d) buf %0d",
                     k, o_rpx, o_rpy, o_rsel, org_x(k), org_y(k), k % 2);
          end
          e = (k == 0) ? accept_cyc + 2 : imax(rd[k-1] + 2, (k >= 2) ? wd[k-2] + 2 : 0);
          vectors++;
          if (c !== e) begin
            miscompares++;
            $display("FAIL rast_start_cycle tile %0d: got %0d want %0d", k, c, e);
          end
          if (k >= 2 && wd[k-2] != NEVER && rd[k-1] != NEVER && wd[k-2] > rd[k-1])
            stall += wd[k-2] - rd[k-1];
          rs_cyc[k] = c;
        end
        rs_n++;
        rdone_at = c + int'($urandom_range(rmax, rmin));
      end
      if (c == rdone_at) begin
        rast_done_d = 1'b1;
        rdone_at = -1;
        k = rs_n - 1;
        if (k < MAXT) begin
          rd[k] = c;
          vectors++;
          if ({o_rpx, o_rpy} !== {org_x(k), org_y(k)}) begin
            miscompares++;
            $display("FAIL rast_origin_stable tile %0d: got (%0d,%0d) want (%0d,%0d)",
                     k, o_rpx, o_rpy, org_x(k), org_y(k));
          end
        end
      end
      if (o_ws) begin
        k = ws_n;
        if (k < n_tiles && k < MAXT) begin
          vectors++;
          if ({o_wpx, o_wpy, o_wsel} !== {org_x(k), org_y(k), 1'(k % 2)}) begin
            miscompares++;
            $display("FAIL wr_origin tile %0d: got (%0d,%0d) buf %0d, want (%0d,%0d) buf %0d",
                     k, o_wpx, o_wpy, o_wsel, org_x(k), org_y(k), k % 2);
          end
          e = (k == 0) ? rd[0] + 2 : imax(rd[k] + 2, wd[k-1] + 2);
          vectors++;
          if (c !== e) begin
            miscompares++;
            $display("FAIL wr_start_cycle tile %0d: got %0d want %0d", k, c, e);
          end
          ws_cyc[k] = c;
        end
        ws_n++;
        wdone_at = c + int'($urandom_range(wmax, wmin));
      end
      if (c == wdone_at) begin
        wr_done_d = 1'b1;
        wdone_at = -1;
        k = ws_n - 1;
        if (k < MAXT) begin
          wd[k] = c;
          vectors++;
          if ({o_wpx, o_wpy} !== {org_x(k), org_y(k)}) begin
            miscompares++;
            $display("FAIL wr_origin_stable tile %0d: got (%0d,%0d) want (%0d,%0d)",
                     k, o_wpx, o_wpy, org_x(k), org_y(k));
          end
        end
      end
      if (o_done) begin
        fd_n++;
        if (fd_n == 1) begin
          fd_cyc = c;
          e = wd[n_tiles-1] + 2;
          vectors++;
          if (c !== e) begin
            miscompares++;
            $display("FAIL frame_done_cycle: got %0d want %0d", c, e);
          end
        end
      end
      if (spam && o_busy && $urandom_range(3, 0) == 0) frame_start_d = 1'b1;
      if (fd_n > 0 && c == fd_cyc + 3) break;
    end
    vectors++;
    if (fd_n == 0) begin
      miscompares++;
      $display("FAIL frame_timeout: got no frame_done within %0d cycles, want one", BUDGET);
      return;
    end
`ifdef TILE_SCHED_PERF_EN
    exp_perf = 32'(stall);
`else
    exp_perf = 32'd0;
`endif
    vectors++;
    if ({o_busy, o_perf} !== {1'b0, exp_perf}) begin
      miscompares++;
      $display("FAIL post_frame busy/perf: got %0d/%0d want 0/%0d", o_busy, o_perf, exp_perf);
    end
  endtask

  task automatic check_counts(input string name);
    vectors++;
    if ({rs_n, ws_n, fd_n} !== {n_tiles, n_tiles, 1}) begin
      miscompares++;
      $display("FAIL %s counts rast/wr/done: got %0d/%0d/%0d want %0d/%0d/1",
               name, rs_n, ws_n, fd_n, n_tiles, n_tiles);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({s_outs, b_outs} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h / %h want all zero", s_outs, b_outs);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({s_outs, b_outs} !== '0) begin
      miscompares++;
      $display("FAIL idle_outputs: got %h / %h want all zero", s_outs, b_outs);
    end
  endtask

  task automatic test_fast();
    use_big = 1'b0; tiles_x = 2; n_tiles = 4;
    run_frame(1, 1, 1, 1, 1'b0, 0);
    check_counts("fast");
  endtask

  task automatic test_slow_writer();
    run_frame(5, 5, 50, 50, 1'b0, 0);
    check_counts("slow_writer");
    vectors++;
    if (!(rs_cyc[2] > wd[0])) begin
      miscompares++;
      $display("FAIL third_rast_wait: got rast_start %0d want after wr_done %0d", rs_cyc[2], wd[0]);
    end
  endtask

  task automatic test_slow_raster();
    run_frame(40, 40, 3, 3, 1'b0, 0);
    check_counts("slow_raster");
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (ws_cyc[k] !== rd[k] + 2) begin
        miscompares++;
        $display("FAIL wr_after_rast tile %0d: got %0d want %0d", k, ws_cyc[k], rd[k] + 2);
      end
    end
  endtask

  task automatic test_frame_start_ignored();
    run_frame(2, 6, 2, 9, 1'b1, 0);
    check_counts("start_ignored");
  endtask

  task automatic test_reset_mid_write();
    run_frame(3, 3, 50, 50, 1'b0, 5);
    vectors++;
    if (o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_frame_busy: got %0d want 1", o_busy);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (s_outs !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_write: got %h want all zero", s_outs);
    end
    reset = 1'b0;
    @(negedge clk);
    run_frame(1, 1, 1, 1, 1'b0, 0);
    check_counts("after_reset");
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      run_frame(1, 12, 1, 25, 1'b0, 0);
      check_counts("random");
    end
  endtask

  task automatic test_full_frame();
    use_big = 1'b1; tiles_x = 20; n_tiles = 300;
    @(negedge clk);
    run_frame(1, 3, 1, 3, 1'b0, 0);
    check_counts("full_frame");
    vectors++;
    if ({o_wpx, o_wpy} !== {16'd608, 16'd448}) begin
      miscompares++;
      $display("FAIL last_wr_origin: got (%0d,%0d) want (608,448)", o_wpx, o_wpy);
    end
  endtask

  initial begin
    test_reset();
    test_fast();
    test_slow_writer();
    test_slow_raster();
    test_frame_start_ignored();
    test_reset_mid_write();
    test_random();
    test_full_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
